ram_sweep_ctrl: RTL
===================

// Module: ram_sweep_ctrl
// PURPOSE
//  Parametrised successor to the fixed 8x256 RAM controller. It owns an inferred
//  single-port RAM and two sequencers.
//  - Write sweep: a key pulse fills every location with an address-derived pattern.
//  - Read loop: a second key pulse cycles through all locations at a paced rate.
//  Inputs come from key_filter pulses; data_out feeds the seg_595_dynamic display path.
// PARAMETERS
//  DATA_W   8          RAM word width, bits
//  ADDR_W   8          address width
//  DEPTH    256        locations used, 2..2**ADDR_W
//  CNT_MAX  9_999_999  read dwell per address = CNT_MAX+1 clocks
//  CNT_W    24         pace counter width, must hold CNT_MAX
// PORTS
//  sys_clk     in   1        clock
//  sys_rst     in   1        reset
//  wr_flag     in   1        1-cycle pulse: start write sweep
//  rd_flag     in   1        1-cycle pulse: toggle read loop
//  busy        out  1        high in WRITE or READ
//  rd_active   out  1        high in READ
//  addr        out  ADDR_W   current RAM address
//  data_out    out  DATA_W   last word read, held
//  data_valid  out  1        1-cycle pulse: data_out just updated
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-high.
//  Reset values: state IDLE, all outputs 0, pace counter 0. RAM contents are not cleared.
//  Reset mid-operation: the next cycle is IDLE and the sweep is abandoned.
//  FSM states: IDLE, WRITE, READ.
//  IDLE:
//   - wr_flag -> WRITE.
//   - rd_flag -> READ.
//   - Both in the same cycle -> WRITE (write has priority).
//  WRITE:
//   - Entry sets addr=0.
//   - Every cycle: wr_en=1, wr_data = addr zero-extended or truncated to DATA_W.
//   - addr increments each cycle. After writing DEPTH-1 -> IDLE, addr back to 0.
//   - Sweep length is exactly DEPTH cycles.
//   - wr_flag and rd_flag are ignored (dropped, not queued).
//  READ:
//   - Entry sets addr=0, cnt=0.
//   - Each READ cycle with cnt==0 issues rd_en at addr.
//   - cnt counts 0..CNT_MAX. At CNT_MAX: cnt<=0 and addr<=addr+1.
//   - addr wraps DEPTH-1 -> 0. The loop runs indefinitely.
//   - rd_flag -> IDLE (toggle off); addr<=0; data_out holds.
//   - wr_flag -> WRITE, aborting the read. Takes priority over a simultaneous rd_flag.
//  Read latency: RAM q is registered, 1 clock after rd_en.
//   - data_out <= q and data_valid=1 in the cycle after rd_en.
//   - data_valid still fires if READ was exited in that same cycle.
//  No read and write occur in the same cycle; the FSM is mutually exclusive.
//  DEPTH < 2**ADDR_W: addresses >= DEPTH are never driven.
// STRUCTURE
//  Shared package ram_pkg:
//   - state encoding localparams S_IDLE=2'd0, S_WRITE=2'd1, S_READ=2'd2.
//   - default width constants.
//  Sub-module sp_ram (DATA_W, ADDR_W):
//   - inferred single-port RAM: sys_clk, addr, wr_en, wr_data, rd_en, q.
//   - q is registered and updates only on rd_en.
//  Top level holds the FSM, the addr counter and the pace counter.
// TESTING  (DATA_W=8, ADDR_W=4, DEPTH=12, CNT_MAX=3)
//  1. wr_flag pulse from IDLE:
//     -> busy high 12 cycles, wr_data 0..11 on addr 0..11, then IDLE with addr=0.
//  2. After (1), rd_flag:
//     -> data_valid every 4 clocks; data_out 0,1,..,11,0,1 (wrap after 11);
//        first valid 2 clocks after the pulse.
//  3. rd_flag while in READ at addr=5:
//     -> IDLE next cycle, rd_active=0, data_out keeps last value, addr=0.
//  4. wr_flag and rd_flag in the same cycle from IDLE -> WRITE.
//     wr_flag during READ -> WRITE next cycle and a full refill.
//  5. rd_flag and wr_flag pulses during WRITE -> ignored; sweep length stays 12.
//  6. sys_rst asserted mid-WRITE at addr=6 -> next cycle all outputs 0 and IDLE.
//     A subsequent read returns the pre-reset data at addr 0..5.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants for the RAM sweep controller: FSM state encoding and the
// default geometry used when the top level is instantiated without overrides.
package ram_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;

    localparam int DATA_W_DEF  = 8;
    localparam int ADDR_W_DEF  = 8;
    localparam int DEPTH_DEF   = 256;
    localparam int CNT_MAX_DEF = 9_999_999;
    localparam int CNT_W_DEF   = 24;

endpackage

// File: rtl/sp_ram.sv
// Inferred single-port RAM with a registered read port that only loads on rd_en,
// so q holds the last word read between accesses.
module sp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              sys_clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] q_q;

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
        if (rd_en) begin
            q_q <= mem_q[addr];
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ram_sweep_ctrl.sv
// RAM sweep controller: a write sweep fills every used location with its own
// address, and a paced read loop cycles through the locations indefinitely.
module ram_sweep_ctrl
    import ram_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int CNT_MAX = CNT_MAX_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              wr_flag,
    input  logic              rd_flag,
    output logic              busy,
    output logic              rd_active,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CNT_MAX);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q;
    logic              seen_q;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] ram_q;

    // Write pattern is the address, zero-extended or truncated to the word width.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_wr_data
            if (gi < ADDR_W) begin : g_bit
                assign wr_data[gi] = addr_q[gi];
            end else begin : g_zero
                assign wr_data[gi] = 1'b0;
            end
        end
    endgenerate

    // Reset blocks the RAM strobes so an abandoned sweep leaves the array untouched.
    assign wr_en = (state_q == S_WRITE) && !sys_rst;
    assign rd_en = (state_q == S_READ) && (cnt_q == '0) && !sys_rst;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (wr_flag) begin
                    state_d = S_WRITE;
                    addr_d  = '0;
                    cnt_d   = '0;
                end else if (rd_flag) begin
                    state_d = S_READ;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_WRITE: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_READ: begin
                if (wr_flag) begin
                    state_d = S_WRITE;
                    addr_d  = '0;
                    cnt_d   = '0;
                end else if (rd_flag) begin
                    state_d = S_IDLE;
                    addr_d  = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            valid_q <= rd_en;
            if (rd_en) begin
                seen_q <= 1'b1;
            end
        end
    end

    sp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .sys_clk (sys_clk),
        .addr    (addr_q),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .q       (ram_q)
    );

    // The RAM output register has no reset; hide it until a read since reset.
    assign data_out   = seen_q ? ram_q : '0;
    assign data_valid = valid_q;
    assign busy       = (state_q != S_IDLE);
    assign rd_active  = (state_q == S_READ);
    assign addr       = addr_q;

endmodule
